// File: rtl/cp0_pkg.sv
// CP0 shared constants: register numbers, bit positions,
// exception codes and the exception handler address.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam int IM_HI  = 15;
  localparam int IM_LO  = 10;
  localparam int EXL    = 1;
  localparam int IE     = 0;
  localparam int BD     = 31;
  localparam int EXC_HI = 6;
  localparam int EXC_LO = 2;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage bus between the pipeline and CP0.
// master = pipeline side, slave = CP0 side.
interface cp0_exc_ctrl_if #(
  parameter int HWINT_W = 6
) ();
  logic [4:0]         A1;
  logic [4:0]         A2;
  logic [31:0]        Din;
  logic               We;
  logic [31:0]        VPC;
  logic               BDIn;
  logic [4:0]         ExcCodeIn;
  logic [HWINT_W-1:0] HWInt;
  logic               EXLClr;
  logic               Req;
  logic [31:0]        EPCOut;
  logic [31:0]        Dout;

  modport master (
    output A1, A2, Din, We, VPC, BDIn,
    output ExcCodeIn, HWInt, EXLClr,
    input  Req, EPCOut, Dout
  );

  modport slave (
    input  A1, A2, Din, We, VPC, BDIn,
    input  ExcCodeIn, HWInt, EXLClr,
    output Req, EPCOut, Dout
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky pending bit (TIP).
// Only built when CP0_COUNT_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        tip
);

  logic wr_count;
  logic wr_cmp;

  assign wr_count = we && (addr == REG_COUNT);
  assign wr_cmp   = we && (addr == REG_COMPARE);

  // count free-runs; an mtc0 beats the increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      compare <= '0;
      tip     <= 1'b0;
    end else begin
      count <= wr_count ? din : count + 32'd1;
      if (wr_cmp) begin
        compare <= din;
        tip     <= 1'b0;
      end else if (count == compare && compare != '0) begin
        tip <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt responder (M stage).
// Optional Count/Compare timer: define CP0_COUNT_EN.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          HWINT_W  = 6,
  parameter logic [31:0] RESET_SR = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  cp0_exc_ctrl_if.slave     bus
);

  logic [HWINT_W-1:0] im_q;
  logic [HWINT_W-1:0] ip_q;
  logic [HWINT_W-1:0] hw;
  logic               exl_q;
  logic               ie_q;
  logic               bd_q;
  logic [4:0]         exc_q;
  logic [31:0]        epc_q;
  logic               int_req;
  logic               exc_req;
  logic               req;
  logic               wr_ok;
  logic [31:0]        sr_rd;
  logic [31:0]        cause_rd;
  logic [31:0]        dout;

`ifdef CP0_COUNT_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        tip;

  cp0_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_ok),
    .addr    (bus.A2),
    .din     (bus.Din),
    .count   (count),
    .compare (compare),
    .tip     (tip)
  );

  // timer pending folds into the top interrupt line
  always_comb begin
    hw = bus.HWInt;
    hw[HWINT_W-1] = bus.HWInt[HWINT_W-1] | tip;
  end
`else
  assign hw = bus.HWInt;
`endif

  assign int_req = (|(hw & im_q)) & ie_q & ~exl_q;
  assign exc_req = (bus.ExcCodeIn != 5'd0) & ~exl_q;
  assign req     = reset & (int_req | exc_req);
  assign wr_ok   = bus.We & ~req;
  assign bus.Req = req;

  // architectural register state
  always_ff @(posedge clk) begin
    if (!reset) begin
      im_q  <= RESET_SR[IM_LO +: HWINT_W];
      exl_q <= RESET_SR[EXL];
      ie_q  <= RESET_SR[IE];
      ip_q  <= '0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      ip_q <= hw;
      if (req) begin
        exl_q <= 1'b1;
        bd_q  <= bus.BDIn;
        exc_q <= int_req ? EXC_INT : bus.ExcCodeIn;
        epc_q <= bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
      end else begin
        if (bus.EXLClr)
          exl_q <= 1'b0;
        if (wr_ok && bus.A2 == REG_SR) begin
          im_q  <= bus.Din[IM_LO +: HWINT_W];
          exl_q <= bus.Din[EXL];
          ie_q  <= bus.Din[IE];
        end
        if (wr_ok && bus.A2 == REG_EPC)
          epc_q <= bus.Din;
      end
    end
  end

  // pack SR/Cause views
  always_comb begin
    sr_rd = '0;
    sr_rd[IM_LO +: HWINT_W] = im_q;
    sr_rd[EXL] = exl_q;
    sr_rd[IE]  = ie_q;
    cause_rd = '0;
    cause_rd[BD] = bd_q;
    cause_rd[IM_LO +: HWINT_W] = ip_q;
    cause_rd[EXC_HI:EXC_LO] = exc_q;
  end

  // mfc0 read mux
  always_comb begin
    dout = '0;
    unique case (1'b1)
      bus.A1 == REG_SR:    dout = sr_rd;
      bus.A1 == REG_CAUSE: dout = cause_rd;
      bus.A1 == REG_EPC:   dout = epc_q;
`ifdef CP0_COUNT_EN
      bus.A1 == REG_COUNT:   dout = count;
      bus.A1 == REG_COMPARE: dout = compare;
`endif
      default: dout = '0;
    endcase
  end

  assign bus.Dout = dout;

  // eret sees an mtc0 EPC still in M
  assign bus.EPCOut =
    (wr_ok && bus.A2 == REG_EPC) ? bus.Din : epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed table,
// hand sequences and random vs. a register model.
module tb_cp0_exc_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  cp0_exc_ctrl_if #(.HWINT_W(6)) bus ();

  cp0_exc_ctrl #(
    .HWINT_W  (6),
    .RESET_SR (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  code;
    logic [5:0]  hw;
    logic        clr;
    logic        req;
    logic [31:0] dout;
    logic [31:0] epco;
  } vec_t;

  vec_t tbl[16];

  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.We = v.we;
    bus.A1 = v.a1;
    bus.A2 = v.a2;
    bus.Din = v.din;
    bus.VPC = v.vpc;
    bus.BDIn = v.bd;
    bus.ExcCodeIn = v.code;
    bus.HWInt = v.hw;
    bus.EXLClr = v.clr;
  endtask

  function automatic vec_t mk(
    input logic we, input logic [4:0] a1,
    input logic [4:0] a2, input logic [31:0] din,
    input logic [31:0] vpc, input logic bd,
    input logic [4:0] code, input logic [5:0] hw,
    input logic clr, input logic req,
    input logic [31:0] dout, input logic [31:0] epco);
    vec_t v;
    v.we = we; v.a1 = a1; v.a2 = a2; v.din = din;
    v.vpc = vpc; v.bd = bd; v.code = code; v.hw = hw;
    v.clr = clr; v.req = req; v.dout = dout; v.epco = epco;
    return v;
  endfunction

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    bus.ExcCodeIn = 5'd8;
    bus.HWInt = 6'h3f;
    #4;
    chk("req_in_reset", {31'd0, bus.Req}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    reset = 1'b1;
    m_sr = 0;
    m_cause = 0;
    m_epc = 0;
  endtask

  // model: expected Req from architectural register words
  function automatic logic m_int(input logic [5:0] hw);
    return ((hw & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req(input logic [5:0] hw,
                                 input logic [4:0] code);
    return m_int(hw) || (code != 0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_edge(input vec_t v);
    logic r;
    logic i;
    r = m_req(v.hw, v.code);
    i = m_int(v.hw);
    m_cause[15:10] = v.hw;
    if (r) begin
      m_sr[1] = 1'b1;
      m_cause[31] = v.bd;
      m_cause[6:2] = i ? 5'd0 : v.code;
      m_epc = v.bd ? v.vpc - 32'd4 : v.vpc;
    end else begin
      if (v.clr) m_sr[1] = 1'b0;
      if (v.we && v.a2 == 12) m_sr = v.din & 32'h0000_fc03;
      if (v.we && v.a2 == 14) m_epc = v.din;
    end
  endtask

  function automatic logic [4:0] rnd_reg();
    logic [4:0] r;
    case ($urandom_range(0, 5))
      0: r = 5'd12;
      1: r = 5'd13;
      2: r = 5'd14;
`ifdef CP0_COUNT_EN
      default: r = 5'd0;
`else
      3: r = 5'd9;
      4: r = 5'd11;
      default: r = 5'($urandom);
`endif
    endcase
    return r;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    idle();
    @(posedge clk);
    #1;

    do_reset();
    for (int k = 12; k <= 14; k++) begin
      bus.A1 = 5'(k);
      #2;
      chk("rst_dout", bus.Dout, 32'h0);
      chk("rst_req", {31'd0, bus.Req}, 32'd0);
      chk("rst_epco", bus.EPCOut, 32'h0);
    end
    @(posedge clk);
    #1;

    tbl[0]  = mk(1, 12, 12, 32'h401, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 12, 0, 0, 32'h3010, 0, 0, 1, 0,
                 1, 32'h401, 0);
    tbl[2]  = mk(0, 14, 0, 0, 0, 0, 0, 1, 0,
                 0, 32'h3010, 32'h3010);
    tbl[3]  = mk(0, 13, 0, 0, 0, 0, 0, 1, 0,
                 0, 32'h400, 32'h3010);
    tbl[4]  = mk(0, 12, 0, 0, 0, 0, 0, 0, 1,
                 0, 32'h403, 32'h3010);
    tbl[5]  = mk(0, 12, 0, 0, 32'h3024, 1, 12, 0, 0,
                 1, 32'h401, 32'h3010);
    tbl[6]  = mk(0, 14, 0, 0, 0, 0, 0, 0, 0,
                 0, 32'h3020, 32'h3020);
    tbl[7]  = mk(0, 13, 0, 0, 0, 0, 0, 0, 1,
                 0, 32'h8000_0030, 32'h3020);
    tbl[8]  = mk(1, 12, 14, 32'hdead, 32'h3040, 0, 10, 1, 0,
                 1, 32'h401, 32'h3020);
    tbl[9]  = mk(0, 14, 0, 0, 0, 0, 0, 1, 0,
                 0, 32'h3040, 32'h3040);
    tbl[10] = mk(0, 13, 0, 0, 0, 0, 0, 1, 1,
                 0, 32'h400, 32'h3040);
    tbl[11] = mk(0, 12, 0, 0, 32'h3050, 0, 0, 1, 0,
                 1, 32'h401, 32'h3040);
    tbl[12] = mk(0, 14, 0, 0, 0, 0, 0, 0, 1,
                 0, 32'h3050, 32'h3050);
    tbl[13] = mk(1, 14, 14, 32'h3100, 0, 0, 0, 0, 0,
                 0, 32'h3050, 32'h3100);
    tbl[14] = mk(1, 14, 13, 32'hffff_ffff, 0, 0, 0, 0, 0,
                 0, 32'h3100, 32'h3100);
    tbl[15] = mk(0, 13, 0, 0, 0, 0, 0, 0, 0,
                 0, 32'h0, 32'h3100);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      #4;
      chk($sformatf("vec%0d_req", i),
          {31'd0, bus.Req}, {31'd0, tbl[i].req});
      chk($sformatf("vec%0d_dout", i), bus.Dout, tbl[i].dout);
      chk($sformatf("vec%0d_epco", i), bus.EPCOut, tbl[i].epco);
      @(posedge clk);
      #1;
    end

    // EXLClr and mtc0 SR.EXL=1 together: mtc0 wins
    drive(mk(1, 0, 12, 32'h403, 0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("mtc0_beats_clr", bus.Dout, 32'h403);
    @(posedge clk);
    #1;

    // EPC wrap-around on a delay-slot victim at PC 0
    drive(mk(0, 0, 12, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(mk(0, 14, 0, 0, 32'h0, 1, 4, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    idle();
    bus.A1 = 5'd14;
    #2;
    chk("epc_wrap", bus.Dout, 32'hffff_fffc);
    @(posedge clk);
    #1;

    do_reset();
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v.we = ($urandom_range(0, 3) == 0);
      v.a1 = rnd_reg();
      v.a2 = rnd_reg();
      v.din = $urandom;
      v.vpc = $urandom;
      v.bd = 1'($urandom);
      v.code = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      v.hw = 6'($urandom);
      v.clr = ($urandom_range(0, 2) == 0);
      drive(v);
      #4;
      v.req = m_req(v.hw, v.code);
      v.epco = (v.we && !v.req && v.a2 == 14) ? v.din : m_epc;
      chk("rnd_req", {31'd0, bus.Req}, {31'd0, v.req});
      chk("rnd_dout", bus.Dout, m_rd(v.a1));
      chk("rnd_epco", bus.EPCOut, v.epco);
      @(posedge clk);
      m_edge(v);
      #1;
    end

`ifdef CP0_COUNT_EN
    begin
      logic seen;
      do_reset();
      drive(mk(1, 0, 12, 32'h8001, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      drive(mk(1, 0, 11, 32'd5, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      drive(mk(1, 0, 9, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      idle();
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        #4;
        seen = bus.Req;
        @(posedge clk);
        #1;
      end
      chk("tip_req", {31'd0, seen}, 32'd1);
      drive(mk(1, 0, 11, 32'd5, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      @(posedge clk);
      #1;
      idle();
      bus.A1 = 5'd13;
      #2;
      chk("tip_clr_req", {31'd0, bus.Req}, 32'd0);
      chk("tip_clr_ip", {31'd0, bus.Dout[15]}, 32'd0);
      @(posedge clk);
      #1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
